// File: rtl/pulse_gen.sv
// pulse_gen -- programmable pulse-train generator.
//
// After an accepted start the block waits delay_ticks cycles, then emits
// pulses of high_ticks cycles separated by low_ticks cycles, and finishes
// with a one-cycle done strobe.
//
// Build option: define PULSE_GEN_REPEAT_EN to enable multi-pulse trains
// (repeat_count and the LOW phase). Without it every start yields exactly
// one pulse and repeat_count / low_ticks are ignored.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         begin a train; only honoured while busy=0
//   abort         stop an active train (priority over everything else)
//   delay_ticks   idle cycles before the first pulse (0 skips the delay)
//   high_ticks    cycles per active phase (0 treated as 1)
//   low_ticks     cycles between pulses (0 treated as 1)
//   repeat_count  pulses per train (0 treated as 1)
//   pulse_out     registered waveform
//   busy          high in DELAY, HIGH and LOW
//   done          one-cycle completion strobe
//   pulses_sent   completed high phases of the current or last train
module pulse_gen #(
  parameter int CNT_W = 32,
  parameter int REP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_ticks,
  input  logic [CNT_W-1:0] high_ticks,
  input  logic [CNT_W-1:0] low_ticks,
  input  logic [REP_W-1:0] repeat_count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] pulses_sent
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // cycles remaining in current phase, minus one
  logic [CNT_W-1:0] high_q, high_d;   // latched, already substituted
  logic [REP_W-1:0] sent_q, sent_d;
  logic             pulse_q, busy_q, done_q;

  logic [CNT_W-1:0] high_eff;
  logic             last_pulse;

  assign high_eff = (high_ticks == '0) ? CNT_W'(1) : high_ticks;

`ifdef PULSE_GEN_REPEAT_EN
  logic [CNT_W-1:0] low_q, low_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] low_eff;
  logic [REP_W-1:0] rep_eff;

  assign low_eff    = (low_ticks == '0) ? CNT_W'(1) : low_ticks;
  assign rep_eff    = (repeat_count == '0) ? REP_W'(1) : repeat_count;
  // sent_q never exceeds rep_q - 1 while in HIGH, so the increment cannot overflow.
  assign last_pulse = ((sent_q + 1'b1) == rep_q);
`else
  logic unused_cfg;
  assign unused_cfg = ^{low_ticks, repeat_count};
  assign last_pulse = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    sent_d  = sent_q;
`ifdef PULSE_GEN_REPEAT_EN
    low_d   = low_q;
    rep_d   = rep_q;
`endif

    if (abort && (state_q == S_DELAY || state_q == S_HIGH || state_q == S_LOW)) begin
      // Abort wins over phase completion: the count of sent pulses is frozen.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (start) begin
            high_d = high_eff;
            sent_d = '0;
`ifdef PULSE_GEN_REPEAT_EN
            low_d  = low_eff;
            rep_d  = rep_eff;
`endif
            if (delay_ticks != '0) begin
              state_d = S_DELAY;
              cnt_d   = delay_ticks - 1'b1;
            end else begin
              state_d = S_HIGH;
              cnt_d   = high_eff - 1'b1;
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) begin
            state_d = S_HIGH;
            cnt_d   = high_q - 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            sent_d = sent_q + 1'b1;
            if (last_pulse) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end else begin
`ifdef PULSE_GEN_REPEAT_EN
              state_d = S_LOW;
              cnt_d   = low_q - 1'b1;
`else
              state_d = S_DONE;
              cnt_d   = '0;
`endif
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_LOW: begin
          if (cnt_q == '0) begin
            state_d = S_HIGH;
            cnt_d   = high_q - 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      high_q  <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PULSE_GEN_REPEAT_EN
      low_q   <= '0;
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      sent_q  <= sent_d;
      // Outputs are registered copies of the next-state decode, so they
      // line up with state_q without any combinational path to the pins.
      pulse_q <= (state_d == S_HIGH);
      busy_q  <= (state_d == S_DELAY) || (state_d == S_HIGH) || (state_d == S_LOW);
      done_q  <= (state_d == S_DONE);
`ifdef PULSE_GEN_REPEAT_EN
      low_q   <= low_d;
      rep_q   <= rep_d;
`endif
    end
  end

  assign pulse_out   = pulse_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_gen.sv
module tb_pulse_gen;
  localparam int CW = 4;
  localparam int RW = 3;

`ifdef PULSE_GEN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] dly = '0, hi = '0, lo = '0;
  logic [RW-1:0] rep = '0;
  logic          pulse_out, busy, done;
  logic [RW-1:0] pulses_sent;

  int n_vec = 0;
  int n_bad = 0;

  pulse_gen #(.CNT_W(CW), .REP_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_ticks(dly), .high_ticks(hi), .low_ticks(lo), .repeat_count(rep),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulses_sent(pulses_sent)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: expected output stream ----------------
  typedef struct { logic p; logic b; logic d; int ps; } exp_t;
  exp_t exp_q[$];
  exp_t cur = '{1'b0, 1'b0, 1'b0, 0};

  function automatic exp_t mk(logic p, logic b, logic d, int ps);
    exp_t e;
    e.p = p; e.b = b; e.d = d; e.ps = ps;
    return e;
  endfunction

  function automatic int eff(int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Lay out the whole train as one expected output value per cycle.
  task automatic build_train(int d, int h, int l, int r);
    int rr;
    rr = REP_EN ? eff(r) : 1;
    exp_q.delete();
    for (int i = 0; i < d; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 0));
    for (int k = 1; k <= rr; k++) begin
      for (int j = 0; j < eff(h); j++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, k - 1));
      if (k < rr)
        for (int j = 0; j < eff(l); j++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, k));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, rr));
  endtask

  task automatic model_edge();
    if (rst) begin
      exp_q.delete();
      cur = mk(1'b0, 1'b0, 1'b0, 0);
    end else if (abort && cur.b) begin
      exp_q.delete();
      cur = mk(1'b0, 1'b0, 1'b0, cur.ps);
    end else if (start && !cur.b) begin
      build_train(int'(dly), int'(hi), int'(lo), int'(rep));
      cur = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = mk(1'b0, 1'b0, 1'b0, cur.ps);
    end
  endtask

  // One clock: DUT and model both advance, then the outputs are compared.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    n_vec++;
    if (pulse_out !== cur.p || busy !== cur.b || done !== cur.d || int'(pulses_sent) != cur.ps) begin
      n_bad++;
      $display("FAIL model t=%0t: got p=%b b=%b d=%b ps=%0d expected p=%b b=%b d=%b ps=%0d",
               $time, pulse_out, busy, done, pulses_sent, cur.p, cur.b, cur.d, cur.ps);
    end
  endtask

  task automatic chk(string nm, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic set_par(int d, int h, int l, int r);
    dly = CW'(d); hi = CW'(h); lo = CW'(l); rep = RW'(r);
  endtask

  // ---------------- directed table ----------------
  typedef struct { int d; int h; int l; int r; int len; int ps; int hc; } vec_t;
  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, hc, seen;
`ifdef PULSE_GEN_REPEAT_EN
    tbl[0] = '{0, 5, 0, 1, 6, 1, 5};
    tbl[1] = '{3, 2, 4, 3, 18, 3, 6};
    tbl[2] = '{0, 0, 0, 0, 2, 1, 1};
    tbl[3] = '{1, 1, 1, 2, 5, 2, 2};
    tbl[4] = '{15, 15, 15, 7, 211, 7, 105};
    tbl[5] = '{0, 3, 0, 2, 8, 2, 6};
`else
    tbl[0] = '{0, 5, 0, 1, 6, 1, 5};
    tbl[1] = '{3, 2, 4, 3, 6, 1, 2};
    tbl[2] = '{0, 0, 0, 0, 2, 1, 1};
    tbl[3] = '{1, 1, 1, 2, 3, 1, 1};
    tbl[4] = '{15, 15, 15, 7, 31, 1, 15};
    tbl[5] = '{0, 3, 0, 2, 4, 1, 3};
`endif

    // Reset with start asserted: start must be ignored.
    set_par(0, 1, 0, 1);
    start = 1'b1;
    repeat (3) cycle();
    chk("rst_pulse", int'(pulse_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ps", int'(pulses_sent), 0);
    rst = 1'b0;
    cycle();
    chk("start_after_rst", int'(pulse_out), 1);
    start = 1'b0;
    repeat (3) cycle();

    // Table of complete trains.
    foreach (tbl[i]) begin
      set_par(tbl[i].d, tbl[i].h, tbl[i].l, tbl[i].r);
      start = 1'b1;
      cycle();
      start = 1'b0;
      len = 1; hc = int'(pulse_out);
      while (!done && len < 400) begin
        cycle();
        len++;
        hc += int'(pulse_out);
      end
      chk($sformatf("tbl%0d_len", i), len, tbl[i].len);
      chk($sformatf("tbl%0d_ps", i), int'(pulses_sent), tbl[i].ps);
      chk($sformatf("tbl%0d_highs", i), hc, tbl[i].hc);
      cycle();
    end

    // Abort on the second HIGH cycle of pulse 2 (pulse 1 without repeat).
    set_par(0, 4, 2, 5);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (REP_EN ? 7 : 1) cycle();
    chk("abort_in_high", int'(pulse_out), 1);
    abort = 1'b1;
    start = 1'b1;
    cycle();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_pulse", int'(pulse_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ps", int'(pulses_sent), REP_EN ? 1 : 0);
    seen = 0;
    repeat (6) begin
      cycle();
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);

    // Back-to-back trains with start held high.
    set_par(0, 1, 0, 1);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk($sformatf("b2b_pulse%0d", i), int'(pulse_out), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("b2b_done%0d", i), int'(done), (i % 2 == 1) ? 1 : 0);
    end
    start = 1'b0;
    repeat (2) cycle();

    // Reset in the middle of a train (LOW phase when repeat is enabled).
    set_par(0, 2, 3, 3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    start = 1'b1;
    cycle();
    chk("midrst_pulse", int'(pulse_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ps", int'(pulses_sent), 0);
    cycle();
    rst = 1'b0;
    start = 1'b0;
    repeat (2) cycle();

    // Start and parameter changes while busy must not disturb the train.
    set_par(2, 3, 2, 2);
    start = 1'b1;
    cycle();
    start = 1'b0;
    len = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (i == 1) begin
        set_par(0, 1, 1, 1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      cycle();
      len++;
    end
    start = 1'b0;
    chk("busy_start_len", len, REP_EN ? 11 : 6);
    chk("busy_start_ps", int'(pulses_sent), REP_EN ? 2 : 1);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0)
        set_par($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      else
        set_par($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
